decode_stage_fwd: RTL and testbench

- Parametrised RV decode stage and DE→EXE pipeline latch; successor to the fixed 64-bit decode block.
- Contains the architectural register file, a MEM/WB forwarding network and an immediate generator.
- Adds a load-use interlock, a downstream ready/flush handshake and valid-qualified forwarding.
- Sits between the fetch latch (DE_*) and the execute stage (EXE_*).

---
 rtl/decode_stage_fwd.sv | 242 ++++++++++++++++++++++++
 tb/tb_decode_stage_fwd.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_fwd.sv
// RV decode stage with register file, MEM/WB forwarding, load-use interlock and DE->EXE latch.
// Optional stall/bubble counters are enabled by defining DECODE_PERF_CNT_EN.
module decode_stage_fwd #(
    parameter int          XLEN   = 64,
    parameter int          NREG   = 32,
    parameter logic [31:0] NOP_IR = 32'h00000013
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            DE_V,
    input  logic [XLEN-1:0] DE_NPC,
    input  logic [31:0]     DE_IR,
    input  logic            LD_AGEX,
    input  logic            FLUSH,
    input  logic            MEM_V,
    input  logic [31:0]     MEM_IR,
    input  logic [XLEN-1:0] MEM_ALU_RESULT,
    input  logic            WB_V,
    input  logic [31:0]     WB_IR,
    input  logic            WB_LD_REG,
    input  logic [XLEN-1:0] WB_DATA,
    output logic            EXE_V,
    output logic [XLEN-1:0] EXE_NPC,
    output logic [31:0]     EXE_IR,
    output logic [XLEN-1:0] EXE_ALU_ONE,
    output logic [XLEN-1:0] EXE_ALU_TWO,
    output logic [XLEN-1:0] EXE_RS2,
    output logic            EXE_ECALL,
    output logic            DE_READY,
    output logic            V_DE_BR_STALL
`ifdef DECODE_PERF_CNT_EN
    ,
    output logic [31:0]     PERF_STALL_CNT,
    output logic [31:0]     PERF_BUBBLE_CNT
`endif
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_OP32   = 7'b0111011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam int SHW = (XLEN == 64) ? 6 : 5;
    localparam int AW  = (NREG > 1) ? $clog2(NREG) : 1;

    function automatic logic writes_rd(input logic [6:0] op, input logic [4:0] rd);
        logic w;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
            OP_IMM, OP_OP, OP_IMM32, OP_OP32, OP_SYSTEM: w = 1'b1;
            default:                                     w = 1'b0;
        endcase
        return w && (rd != 5'd0);
    endfunction

    function automatic logic in_rf(input logic [4:0] r);
        return int'(r) < NREG;
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic signed [XLEN-1:0] t;
        t = $signed(v);
        return t;
    endfunction

    logic [6:0] op;
    logic [4:0] rs1, rs2, mem_rd, wb_rd, exe_rd;
    logic [2:0] f3;

    assign op     = DE_IR[6:0];
    assign f3     = DE_IR[14:12];
    assign rs1    = DE_IR[19:15];
    assign rs2    = DE_IR[24:20];
    assign mem_rd = MEM_IR[11:7];
    assign wb_rd  = WB_IR[11:7];
    assign exe_rd = EXE_IR[11:7];

    logic unused_ir;
    assign unused_ir = ^{MEM_IR[31:12], WB_IR[31:12], WB_IR[6:0]};

    // Register file: no reset, written from WB, read with write-through.
    logic [XLEN-1:0] rf_q [NREG];
    logic            wb_ld, wb_wr;

    assign wb_ld = WB_V && WB_LD_REG;
    assign wb_wr = wb_ld && (wb_rd != 5'd0);

    always_ff @(posedge CLK) begin
        if (wb_wr && in_rf(wb_rd)) rf_q[wb_rd[AW-1:0]] <= WB_DATA;
    end

    logic [XLEN-1:0] rs1_rf, rs2_rf, rs1_fwd, rs2_fwd;

    always_comb begin
        rs1_rf = '0;
        rs2_rf = '0;
        if (rs1 != 5'd0 && in_rf(rs1))
            rs1_rf = (wb_wr && wb_rd == rs1) ? WB_DATA : rf_q[rs1[AW-1:0]];
        if (rs2 != 5'd0 && in_rf(rs2))
            rs2_rf = (wb_wr && wb_rd == rs2) ? WB_DATA : rf_q[rs2[AW-1:0]];
    end

    // A load in MEM has no data yet, so only non-load MEM results are forwarded.
    logic mem_fwd_ok;
    assign mem_fwd_ok = MEM_V && writes_rd(MEM_IR[6:0], mem_rd) && (MEM_IR[6:0] != OP_LOAD);

    always_comb begin
        rs1_fwd = rs1_rf;
        rs2_fwd = rs2_rf;
        if (mem_fwd_ok && mem_rd == rs1)               rs1_fwd = MEM_ALU_RESULT;
        else if (wb_ld && wb_rd == rs1 && rs1 != 5'd0) rs1_fwd = WB_DATA;
        if (mem_fwd_ok && mem_rd == rs2)               rs2_fwd = MEM_ALU_RESULT;
        else if (wb_ld && wb_rd == rs2 && rs2 != 5'd0) rs2_fwd = WB_DATA;
    end

    logic use_rs1, use_rs2, exe_ld, mem_ld, hz1, hz2, stall, bubble;

    assign use_rs1 = !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    assign use_rs2 = (op == OP_OP || op == OP_OP32 || op == OP_STORE || op == OP_BRANCH);
    assign exe_ld  = EXE_V && (EXE_IR[6:0] == OP_LOAD);
    assign mem_ld  = MEM_V && (MEM_IR[6:0] == OP_LOAD);
    assign hz1     = use_rs1 && rs1 != 5'd0 &&
                     ((exe_ld && exe_rd == rs1) || (mem_ld && mem_rd == rs1));
    assign hz2     = use_rs2 && rs2 != 5'd0 &&
                     ((exe_ld && exe_rd == rs2) || (mem_ld && mem_rd == rs2));
    assign stall   = DE_V && (hz1 || hz2);
    assign bubble  = FLUSH || !DE_V || stall;

    assign DE_READY      = LD_AGEX && !stall;
    assign V_DE_BR_STALL = DE_V && (op == OP_BRANCH || op == OP_JAL || op == OP_JALR);

    logic [XLEN-1:0] imm, alu1, alu2;

    always_comb begin
        imm = sext32({{20{DE_IR[31]}}, DE_IR[31:20]});
        case (op)
            OP_STORE:         imm = sext32({{20{DE_IR[31]}}, DE_IR[31:25], DE_IR[11:7]});
            OP_LUI, OP_AUIPC: imm = sext32({DE_IR[31:12], 12'b0});
            OP_JAL:           imm = sext32({{12{DE_IR[31]}}, DE_IR[19:12], DE_IR[20],
                                            DE_IR[30:21], 1'b0});
            OP_IMM:   if (f3 == 3'b001 || f3 == 3'b101) imm = XLEN'(DE_IR[20 +: SHW]);
            OP_IMM32: if (f3 == 3'b001 || f3 == 3'b101) imm = XLEN'(DE_IR[24:20]);
            default: ;
        endcase
    end

    always_comb begin
        alu1 = rs1_fwd;
        if (op == OP_AUIPC || op == OP_JAL)  alu1 = DE_NPC - XLEN'(4);
        else if (op == OP_LUI)               alu1 = '0;
        else if (op == OP_SYSTEM && f3[2])   alu1 = XLEN'(rs1);
        alu2 = (op == OP_OP || op == OP_OP32 || op == OP_BRANCH) ? rs2_fwd : imm;
    end

    logic            exe_v_q, exe_v_d, ecall_q, ecall_d;
    logic [XLEN-1:0] npc_q, npc_d, alu1_q, alu1_d, alu2_q, alu2_d, rs2_q, rs2_d;
    logic [31:0]     ir_q, ir_d;

    always_comb begin
        exe_v_d = exe_v_q;
        ecall_d = ecall_q;
        npc_d   = npc_q;
        ir_d    = ir_q;
        alu1_d  = alu1_q;
        alu2_d  = alu2_q;
        rs2_d   = rs2_q;
        if (LD_AGEX) begin
            if (bubble) begin
                exe_v_d = 1'b0;
                ir_d    = NOP_IR;
                ecall_d = 1'b0;
            end else begin
                exe_v_d = 1'b1;
                ir_d    = DE_IR;
                ecall_d = (DE_IR == 32'h00000073);
                npc_d   = DE_NPC;
                alu1_d  = alu1;
                alu2_d  = alu2;
                rs2_d   = rs2_fwd;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exe_v_q <= 1'b0;
            ecall_q <= 1'b0;
            ir_q    <= NOP_IR;
            npc_q   <= '0;
            alu1_q  <= '0;
            alu2_q  <= '0;
            rs2_q   <= '0;
        end else begin
            exe_v_q <= exe_v_d;
            ecall_q <= ecall_d;
            ir_q    <= ir_d;
            npc_q   <= npc_d;
            alu1_q  <= alu1_d;
            alu2_q  <= alu2_d;
            rs2_q   <= rs2_d;
        end
    end

    assign EXE_V       = exe_v_q;
    assign EXE_ECALL   = ecall_q;
    assign EXE_IR      = ir_q;
    assign EXE_NPC     = npc_q;
    assign EXE_ALU_ONE = alu1_q;
    assign EXE_ALU_TWO = alu2_q;
    assign EXE_RS2     = rs2_q;

`ifdef DECODE_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, bub_cnt_q, bub_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'b0, stall && LD_AGEX};
        bub_cnt_d   = bub_cnt_q + {31'b0, bubble && LD_AGEX};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            bub_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            bub_cnt_q   <= bub_cnt_d;
        end
    end

    assign PERF_STALL_CNT  = stall_cnt_q;
    assign PERF_BUBBLE_CNT = bub_cnt_q;
`endif

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Directed bench for decode_stage_fwd: a 64-bit and a 32-bit instance share one stimulus stream.
module tb_decode_stage_fwd;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        DE_V = 1'b0, LD_AGEX = 1'b1, FLUSH = 1'b0;
    logic [63:0] DE_NPC = '0, MEM_ALU_RESULT = '0, WB_DATA = '0;
    logic [31:0] DE_IR = 32'h13, MEM_IR = 32'h13, WB_IR = 32'h13;
    logic        MEM_V = 1'b0, WB_V = 1'b0, WB_LD_REG = 1'b0;

    logic        e_v, e_ecall, de_ready, br_stall;
    logic [63:0] e_npc, e_a1, e_a2, e_rs2;
    logic [31:0] e_ir;
    logic        f_v, f_ecall, f_ready, f_br;
    logic [31:0] f_npc, f_a1, f_a2, f_rs2, f_ir;
`ifdef DECODE_PERF_CNT_EN
    logic [31:0] e_sc, e_bc, f_sc, f_bc;
`endif

    always #5 CLK = ~CLK;

    decode_stage_fwd #(.XLEN(64)) dut64 (
        .CLK(CLK), .RST(RST), .DE_V(DE_V), .DE_NPC(DE_NPC), .DE_IR(DE_IR),
        .LD_AGEX(LD_AGEX), .FLUSH(FLUSH), .MEM_V(MEM_V), .MEM_IR(MEM_IR),
        .MEM_ALU_RESULT(MEM_ALU_RESULT), .WB_V(WB_V), .WB_IR(WB_IR),
        .WB_LD_REG(WB_LD_REG), .WB_DATA(WB_DATA), .EXE_V(e_v), .EXE_NPC(e_npc),
        .EXE_IR(e_ir), .EXE_ALU_ONE(e_a1), .EXE_ALU_TWO(e_a2), .EXE_RS2(e_rs2),
        .EXE_ECALL(e_ecall), .DE_READY(de_ready), .V_DE_BR_STALL(br_stall)
`ifdef DECODE_PERF_CNT_EN
        , .PERF_STALL_CNT(e_sc), .PERF_BUBBLE_CNT(e_bc)
`endif
    );

    decode_stage_fwd #(.XLEN(32)) dut32 (
        .CLK(CLK), .RST(RST), .DE_V(DE_V), .DE_NPC(DE_NPC[31:0]), .DE_IR(DE_IR),
        .LD_AGEX(LD_AGEX), .FLUSH(FLUSH), .MEM_V(MEM_V), .MEM_IR(MEM_IR),
        .MEM_ALU_RESULT(MEM_ALU_RESULT[31:0]), .WB_V(WB_V), .WB_IR(WB_IR),
        .WB_LD_REG(WB_LD_REG), .WB_DATA(WB_DATA[31:0]), .EXE_V(f_v), .EXE_NPC(f_npc),
        .EXE_IR(f_ir), .EXE_ALU_ONE(f_a1), .EXE_ALU_TWO(f_a2), .EXE_RS2(f_rs2),
        .EXE_ECALL(f_ecall), .DE_READY(f_ready), .V_DE_BR_STALL(f_br)
`ifdef DECODE_PERF_CNT_EN
        , .PERF_STALL_CNT(f_sc), .PERF_BUBBLE_CNT(f_bc)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [4:0] rd);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic wb_write(input logic [4:0] rd, input logic [63:0] data);
        WB_V = 1'b1; WB_LD_REG = 1'b1; WB_DATA = data;
        WB_IR = itype(12'h0, 5'd0, 3'b000, rd, 7'b0010011);
    endtask

    task automatic wb_off();
        WB_V = 1'b0; WB_LD_REG = 1'b0;
    endtask

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] LDO = 7'b0000011;

    logic [31:0] jal_w, ld_w;

    initial begin
        jal_w = {1'b1, 10'b1111111100, 1'b1, 8'hFF, 5'd1, 7'b1101111};
        ld_w  = itype(12'h0, 5'd1, 3'b011, 5'd7, LDO);

        tick(); tick();
        chk("rst_v", {63'b0, e_v}, 64'd0);
        chk("rst_ir", {32'b0, e_ir}, 64'h13);
        chk("rst_ecall", {63'b0, e_ecall}, 64'd0);
        chk("rst_a1", e_a1, 64'd0);
        chk("rst_ir32", {32'b0, f_ir}, 64'h13);
        RST = 1'b0;

        wb_write(5'd5, 64'd0);        tick();
        wb_write(5'd1, 64'h1000);     tick();
        wb_write(5'd2, 64'h2222);     tick();
        wb_off();

        MEM_V = 1'b1; MEM_IR = itype(12'h123, 5'd0, 3'b000, 5'd5, OPI);
        MEM_ALU_RESULT = 64'h1234;
        DE_V = 1'b1; DE_IR = rtype(5'd5, 5'd5, 5'd6); DE_NPC = 64'h104;
        #1 chk("memfwd_ready", {63'b0, de_ready}, 64'd1);
        tick();
        chk("memfwd_v", {63'b0, e_v}, 64'd1);
        chk("memfwd_a1", e_a1, 64'h1234);
        chk("memfwd_a2", e_a2, 64'h1234);
        chk("memfwd_rs2", e_rs2, 64'h1234);
        chk("memfwd_npc", e_npc, 64'h104);
        chk("memfwd_a1_32", {32'b0, f_a1}, 64'h1234);

        MEM_V = 1'b0;
        DE_IR = ld_w; DE_NPC = 64'h108;
        tick();
        chk("ld_v", {63'b0, e_v}, 64'd1);
        chk("ld_a1", e_a1, 64'h1000);
        DE_IR = itype(12'd1, 5'd7, 3'b000, 5'd8, OPI); DE_NPC = 64'h10C;
        #1 chk("lu_ready0", {63'b0, de_ready}, 64'd0);
        tick();
        chk("lu_bub0_v", {63'b0, e_v}, 64'd0);
        chk("lu_bub0_ir", {32'b0, e_ir}, 64'h13);
        MEM_V = 1'b1; MEM_IR = ld_w;
        #1 chk("lu_ready1", {63'b0, de_ready}, 64'd0);
        tick();
        chk("lu_bub1_v", {63'b0, e_v}, 64'd0);
        MEM_V = 1'b0; MEM_IR = 32'h13;
        WB_V = 1'b1; WB_LD_REG = 1'b1; WB_IR = ld_w; WB_DATA = 64'hDEAD;
        #1 chk("lu_ready2", {63'b0, de_ready}, 64'd1);
        tick();
        chk("lu_v", {63'b0, e_v}, 64'd1);
        chk("lu_a1", e_a1, 64'hDEAD);
        chk("lu_a2", e_a2, 64'd1);
        chk("lu_a1_32", {32'b0, f_a1}, 64'hDEAD);
        wb_off();

        DE_IR = {7'h7F, 5'd2, 5'd1, 3'b010, 5'h1C, 7'b0100011};
        tick();
        chk("sw_a2_64", e_a2, 64'hFFFFFFFFFFFFFFFC);
        chk("sw_a2_32", {32'b0, f_a2}, 64'hFFFFFFFC);
        chk("sw_a1", e_a1, 64'h1000);
        chk("sw_rs2", e_rs2, 64'h2222);

        DE_IR = {20'h80000, 5'd3, 7'b0110111};
        tick();
        chk("lui_a1", e_a1, 64'd0);
        chk("lui_a2_64", e_a2, 64'hFFFFFFFF80000000);
        chk("lui_a2_32", {32'b0, f_a2}, 64'h80000000);

        DE_IR = itype(12'd40, 5'd1, 3'b001, 5'd4, OPI);
        tick();
        chk("slli_a2_64", e_a2, 64'd40);
        chk("slli_a2_32", {32'b0, f_a2}, 64'd8);

        DE_IR = {1'b1, 6'h3F, 5'd0, 5'd0, 3'b000, 4'b1100, 1'b1, 7'b1100011};
        #1 chk("beq_brstall", {63'b0, br_stall}, 64'd1);
        tick();
        chk("beq_v", {63'b0, e_v}, 64'd1);
        chk("beq_a2", e_a2, 64'd0);

        DE_IR = jal_w; DE_NPC = 64'h200;
        #1 chk("jal_brstall", {63'b0, br_stall}, 64'd1);
        tick();
        chk("jal_a1", e_a1, 64'h1FC);
        chk("jal_a2_64", e_a2, 64'hFFFFFFFFFFFFFFF8);
        chk("jal_a2_32", {32'b0, f_a2}, 64'hFFFFFFF8);

        LD_AGEX = 1'b0; FLUSH = 1'b1;
        DE_IR = rtype(5'd5, 5'd5, 5'd6); DE_NPC = 64'h300;
        #1 chk("hold_ready", {63'b0, de_ready}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_v", {63'b0, e_v}, 64'd1);
            chk("hold_ir", {32'b0, e_ir}, {32'b0, jal_w});
            chk("hold_npc", e_npc, 64'h200);
        end
        LD_AGEX = 1'b1;
        tick();
        chk("flush_v", {63'b0, e_v}, 64'd0);
        chk("flush_ir", {32'b0, e_ir}, 64'h13);
        chk("flush_npc_hold", e_npc, 64'h200);
        FLUSH = 1'b0; DE_IR = 32'h00000073; DE_NPC = 64'h304;
        tick();
        chk("ecall", {63'b0, e_ecall}, 64'd1);
        chk("ecall_v", {63'b0, e_v}, 64'd1);

        wb_write(5'd0, 64'h55);
        DE_IR = rtype(5'd0, 5'd0, 5'd10);
        tick();
        chk("x0_a1", e_a1, 64'd0);
        chk("x0_a2", e_a2, 64'd0);
        chk("x0_ecall", {63'b0, e_ecall}, 64'd0);
        wb_write(5'd9, 64'h99);
        DE_IR = itype(12'd0, 5'd9, 3'b000, 5'd11, OPI);
        tick();
        chk("wbbyp_a1", e_a1, 64'h99);
        wb_off();
        DE_IR = itype(12'd2, 5'd9, 3'b000, 5'd12, OPI);
        tick();
        chk("rf_x9_a1", e_a1, 64'h99);
        chk("rf_x9_a2", e_a2, 64'd2);

        chk("pre_rst_v", {63'b0, e_v}, 64'd1);
        #3 RST = 1'b1;
        #1;
        chk("arst_v", {63'b0, e_v}, 64'd0);
        chk("arst_ir", {32'b0, e_ir}, 64'h13);
        chk("arst_a1", e_a1, 64'd0);
        chk("arst_v32", {63'b0, f_v}, 64'd0);
        #2 RST = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
